// File: rtl/uart_rx_sampler_pkg.sv
// Shared definitions for the oversampling UART receiver (and a future uart_tx).
package uart_rx_sampler_pkg;

  localparam int OVERSAMPLE_DEF = 16;
  localparam int DATA_BITS_DEF  = 8;
  // start + 8 data + 1 stop
  localparam int FRAME_BITS_8N1 = 1 + DATA_BITS_DEF + 1;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_START   = 3'd1,
    ST_DATA    = 3'd2,
    ST_STOP    = 3'd3,
    ST_WAIT_HI = 3'd4
  } rx_state_e;

endpackage

// File: rtl/uart_rx_sampler_if.sv
// Serial-line input and received-byte output bundle of the UART receiver.
// Handshake: rx_valid is a single-cycle pulse with no back-pressure; rx_data is
// new in that cycle and holds until the next good frame. rx_frame_err is a
// single-cycle pulse with rx_data unchanged. rx_state mirrors the receiver FSM.
interface uart_rx_sampler_if #(
  parameter int DATA_BITS = uart_rx_sampler_pkg::DATA_BITS_DEF
);
  import uart_rx_sampler_pkg::*;

  logic                 sample_tick;
  logic                 rx_in;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_frame_err;
  logic                 rx_busy;
  rx_state_e            rx_state;

  // Receiver side
  modport master (
    input  sample_tick, rx_in,
    output rx_data, rx_valid, rx_frame_err, rx_busy, rx_state
  );

  // Line driver / byte consumer side
  modport slave (
    output sample_tick, rx_in,
    input  rx_data, rx_valid, rx_frame_err, rx_busy, rx_state
  );

endinterface

// File: rtl/uart_rx_sampler_sync_2ff.sv
// Two-flop synchroniser for a single asynchronous bit, with a reset value.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // Two back-to-back flops; reset forces both to the idle level
  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx_sampler.sv
// Oversampling 8N1 UART receiver: synchronises rx_in, finds the start-bit
// midpoint, samples each data bit and the stop bit at its midpoint.
module uart_rx_sampler
  import uart_rx_sampler_pkg::*;
#(
  parameter int OVERSAMPLE = OVERSAMPLE_DEF,
  parameter int DATA_BITS  = DATA_BITS_DEF
) (
  input  logic               clk,
  input  logic               reset,
  uart_rx_sampler_if.master  bus
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [TW-1:0] HALF_LAST = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

  logic                 rx_s;
  rx_state_e            state_q;
  logic [TW-1:0]        tick_cnt_q;
  logic [BW-1:0]        bit_cnt_q;
  logic [DATA_BITS-1:0] shift_q;
  logic [DATA_BITS-1:0] data_q;
  logic                 valid_q;
  logic                 ferr_q;

  sync_2ff #(.RESET_VAL(1'b1)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d_i   (bus.rx_in),
    .q_o   (rx_s)
  );

  // Receiver FSM with counters, shift register and registered output pulses
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      tick_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      // Pulses last exactly one clk, independent of sample_tick
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      if (bus.sample_tick) begin
        case (state_q)
          ST_IDLE: begin
            if (!rx_s) begin
              state_q    <= ST_START;
              tick_cnt_q <= '0;
            end
          end
          ST_START: begin
            if (tick_cnt_q == HALF_LAST) begin
              tick_cnt_q <= '0;
              bit_cnt_q  <= '0;
              // A line that is high again at the start midpoint was a glitch
              state_q    <= rx_s ? ST_IDLE : ST_DATA;
            end else begin
              tick_cnt_q <= tick_cnt_q + 1'b1;
            end
          end
          ST_DATA: begin
            if (tick_cnt_q == TICK_LAST) begin
              tick_cnt_q <= '0;
              shift_q    <= {rx_s, shift_q[DATA_BITS-1:1]};
              bit_cnt_q  <= bit_cnt_q + 1'b1;
              if (bit_cnt_q == BIT_LAST) state_q <= ST_STOP;
            end else begin
              tick_cnt_q <= tick_cnt_q + 1'b1;
            end
          end
          ST_STOP: begin
            if (tick_cnt_q == TICK_LAST) begin
              tick_cnt_q <= '0;
              if (rx_s) begin
                data_q  <= shift_q;
                valid_q <= 1'b1;
                state_q <= ST_IDLE;
              end else begin
                ferr_q  <= 1'b1;
                state_q <= ST_WAIT_HI;
              end
            end else begin
              tick_cnt_q <= tick_cnt_q + 1'b1;
            end
          end
          ST_WAIT_HI: begin
            // A held-low line (break) must not be decoded as 0x00 frames
            if (rx_s) state_q <= ST_IDLE;
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.rx_data      = data_q;
  assign bus.rx_valid     = valid_q;
  assign bus.rx_frame_err = ferr_q;
  assign bus.rx_busy      = (state_q != ST_IDLE);
  assign bus.rx_state     = state_q;

endmodule
